// File: rtl/poker_frame_rx_param_pkg.sv
// Shared protocol constants and types for the poker link frame parser.
// Header/subtype bytes, error codes and FSM encodings are also used by the TX-side framer.
package poker_frame_rx_param_pkg;

  localparam logic [7:0] HDR_PASS   = 8'hF0;
  localparam logic [7:0] HDR_DEAL   = 8'hF1;
  localparam logic [7:0] HDR_PLAY   = 8'hF2;

  localparam logic [7:0] SUB_FIRST  = 8'hFA;
  localparam logic [7:0] SUB_SECOND = 8'hFB;
  localparam logic [7:0] SUB_PLAY1  = 8'h01;
  localparam logic [7:0] SUB_PLAY2  = 8'h02;
  localparam logic [7:0] SUB_PASS   = 8'hF0;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SUBTYPE = 2'b01;
  localparam logic [1:0] ERR_LENGTH  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SUB  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_PASS = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    FT_PASS = 2'd0,
    FT_DEAL = 2'd1,
    FT_PLAY = 2'd2
  } frame_t;

  // Rank 2 and ace sort above king on the compare side, so they are moved to the top codes.
  function automatic logic [3:0] map_rank(input logic [3:0] rank);
    case (rank)
      4'h2:    return 4'hF;
      4'h1:    return 4'hE;
      default: return rank;
    endcase
  endfunction

endpackage

// File: rtl/poker_frame_rx_param_card_rank_map.sv
// Combinational card rank remap: high nibble 2->F, 1->E, other ranks and the suit nibble pass through.
module card_rank_map
  import poker_frame_rx_param_pkg::*;
(
  input  logic [7:0] card_in,
  output logic [7:0] card_out
);

  assign card_out = {map_rank(card_in[7:4]), card_in[3:0]};

endmodule

// File: rtl/poker_frame_rx_param.sv
// UART-side frame parser for the poker link: decodes deal, opponent-play and opponent-pass frames
// into atomically updated card vectors, with length checking and an inter-byte timeout.
//
// state | meaning
// IDLE  | waiting for a header byte F0/F1/F2, anything else ignored
// SUB   | header seen, checking the subtype byte
// LEN   | checking the card count byte (1..MAX_CARDS)
// DATA  | collecting cards into the shadow buffer, commit on the last one
// PASS  | pass frame, the trailing byte completes it
module poker_frame_rx_param
  import poker_frame_rx_param_pkg::*;
#(
  parameter int MAX_CARDS   = 20,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter bit MAP_RANKS   = 1'b1,
  localparam int CW = $clog2(MAX_CARDS + 1)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [8*MAX_CARDS-1:0] hand_cards,
  output logic [CW-1:0]          hand_cnt,
  output logic                   hand_valid,
  output logic                   first_out,
  output logic [8*MAX_CARDS-1:0] play_cards,
  output logic [CW-1:0]          play_cnt,
  output logic                   play_valid,
  output logic                   pass_valid,
  output logic                   frame_err,
  output logic [1:0]             err_code
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    MAX_LEN  = 8'(MAX_CARDS);

  rx_state_t state_q, state_d;
  frame_t    ftype_q, hdr_type;
  logic      first_pend_q;
  logic [CW-1:0] len_q, idx_q;
  logic [TW-1:0] tmo_q;
  logic [MAX_CARDS-1:0][7:0] shadow_q;
  logic [MAX_CARDS-1:0][7:0] commit_cards;

  logic       tmo_hit, hdr_ok, sub_ok, len_ok, store, commit, pass_hit, err_hit;
  logic [1:0] err_d;
  logic [7:0] mapped_byte, card_byte;

  card_rank_map u_rank_map (
    .card_in  (rx_data),
    .card_out (mapped_byte)
  );

  assign card_byte = MAP_RANKS ? mapped_byte : rx_data;

  always_comb begin
    case (rx_data)
      HDR_DEAL: hdr_type = FT_DEAL;
      HDR_PLAY: hdr_type = FT_PLAY;
      default:  hdr_type = FT_PASS;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timeout is checked ahead of rx_valid so an expiring frame drops the byte in the same cycle.
  always_comb begin
    state_d  = state_q;
    hdr_ok   = 1'b0;
    sub_ok   = 1'b0;
    len_ok   = 1'b0;
    store    = 1'b0;
    commit   = 1'b0;
    pass_hit = 1'b0;
    err_hit  = 1'b0;
    err_d    = ERR_NONE;
    tmo_hit  = (state_q != ST_IDLE) && (tmo_q == '0);

    if (tmo_hit) begin
      err_hit = 1'b1;
      err_d   = ERR_TIMEOUT;
      state_d = ST_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == HDR_PASS || rx_data == HDR_DEAL || rx_data == HDR_PLAY) begin
            hdr_ok  = 1'b1;
            state_d = ST_SUB;
          end
        end
        ST_SUB: begin
          case (ftype_q)
            FT_DEAL: sub_ok = (rx_data == SUB_FIRST) || (rx_data == SUB_SECOND);
            FT_PLAY: sub_ok = (rx_data == SUB_PLAY1) || (rx_data == SUB_PLAY2);
            default: sub_ok = (rx_data == SUB_PASS);
          endcase
          if (sub_ok) begin
            state_d = (ftype_q == FT_PASS) ? ST_PASS : ST_LEN;
          end else begin
            err_hit = 1'b1;
            err_d   = ERR_SUBTYPE;
            state_d = ST_IDLE;
          end
        end
        ST_LEN: begin
          if (rx_data != 8'h00 && rx_data <= MAX_LEN) begin
            len_ok  = 1'b1;
            state_d = ST_DATA;
          end else begin
            err_hit = 1'b1;
            err_d   = ERR_LENGTH;
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          store = 1'b1;
          if (idx_q == len_q - CW'(1)) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_PASS: begin
          pass_hit = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Final card comes straight from the input; stale shadow slots beyond LEN are zeroed.
  always_comb begin
    for (int i = 0; i < MAX_CARDS; i++) begin
      if (CW'(i) == idx_q) begin
        commit_cards[i] = card_byte;
      end else if (CW'(i) < len_q) begin
        commit_cards[i] = shadow_q[i];
      end else begin
        commit_cards[i] = 8'h00;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ftype_q      <= FT_PASS;
      first_pend_q <= 1'b0;
      len_q        <= '0;
      idx_q        <= '0;
      tmo_q        <= TMO_LOAD;
      shadow_q     <= '0;
      hand_cards   <= '0;
      hand_cnt     <= '0;
      hand_valid   <= 1'b0;
      first_out    <= 1'b0;
      play_cards   <= '0;
      play_cnt     <= '0;
      play_valid   <= 1'b0;
      pass_valid   <= 1'b0;
      frame_err    <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      hand_valid <= 1'b0;
      play_valid <= 1'b0;
      pass_valid <= pass_hit;
      frame_err  <= err_hit;

      if (state_q == ST_IDLE || rx_valid) begin
        tmo_q <= TMO_LOAD;
      end else if (tmo_q != '0) begin
        tmo_q <= tmo_q - TW'(1);
      end

      if (hdr_ok) begin
        ftype_q <= hdr_type;
      end
      if (sub_ok && ftype_q == FT_DEAL) begin
        first_pend_q <= (rx_data == SUB_FIRST);
      end
      if (len_ok) begin
        len_q <= rx_data[CW-1:0];
        idx_q <= '0;
      end
      if (store) begin
        idx_q <= idx_q + CW'(1);
        for (int i = 0; i < MAX_CARDS; i++) begin
          if (CW'(i) == idx_q) begin
            shadow_q[i] <= card_byte;
          end
        end
      end

      if (commit) begin
        if (ftype_q == FT_DEAL) begin
          hand_cards <= commit_cards;
          hand_cnt   <= len_q;
          first_out  <= first_pend_q;
          hand_valid <= 1'b1;
        end else begin
          play_cards <= commit_cards;
          play_cnt   <= len_q;
          play_valid <= 1'b1;
        end
      end

      if (err_hit) begin
        err_code <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_poker_frame_rx_param.sv
// Scoreboard bench for poker_frame_rx_param: stimulus pushes expected output snapshots,
// a negedge monitor pops one whenever a result pulse appears and compares every output.
`timescale 1ns/1ps
module tb_poker_frame_rx_param;

  localparam int MAXC = 20;
  localparam int TMO  = 16;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int VW   = 8 * MAXC;
  localparam int K_HAND = 0;
  localparam int K_PLAY = 1;
  localparam int K_PASS = 2;
  localparam int K_ERR  = 3;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int            kind;
    logic [VW-1:0] hand;
    logic [CW-1:0] hcnt;
    logic          first;
    logic [VW-1:0] play;
    logic [CW-1:0] pcnt;
    logic [1:0]    err;
  } exp_t;

  logic          sys_clk;
  logic          sys_rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [VW-1:0] hand_cards;
  logic [CW-1:0] hand_cnt;
  logic          hand_valid;
  logic          first_out;
  logic [VW-1:0] play_cards;
  logic [CW-1:0] play_cnt;
  logic          play_valid;
  logic          pass_valid;
  logic          frame_err;
  logic [1:0]    err_code;

  poker_frame_rx_param #(
    .MAX_CARDS   (MAXC),
    .TIMEOUT_CYC (TMO),
    .MAP_RANKS   (1'b1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .hand_cards (hand_cards),
    .hand_cnt   (hand_cnt),
    .hand_valid (hand_valid),
    .first_out  (first_out),
    .play_cards (play_cards),
    .play_cnt   (play_cnt),
    .play_valid (play_valid),
    .pass_valid (pass_valid),
    .frame_err  (frame_err),
    .err_code   (err_code)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  exp_t  exp_q[$];
  string name_q[$];

  logic [VW-1:0] m_hand;
  logic [CW-1:0] m_hcnt;
  logic          m_first;
  logic [VW-1:0] m_play;
  logic [CW-1:0] m_pcnt;
  logic [1:0]    m_err;

  function automatic logic [VW-1:0] pack(input byte_q_t c);
    logic [VW-1:0] r;
    r = '0;
    foreach (c[i]) r[8*i +: 8] = c[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input string nm);
    exp_t e;
    e.kind  = kind;
    e.hand  = m_hand;
    e.hcnt  = m_hcnt;
    e.first = m_first;
    e.play  = m_play;
    e.pcnt  = m_pcnt;
    e.err   = m_err;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_outputs(input string nm);
    chk({nm, "_hand_cards"}, hand_cards, m_hand);
    chk({nm, "_hand_cnt"}, VW'(hand_cnt), VW'(m_hcnt));
    chk({nm, "_first_out"}, VW'(first_out), VW'(m_first));
    chk({nm, "_play_cards"}, play_cards, m_play);
    chk({nm, "_play_cnt"}, VW'(play_cnt), VW'(m_pcnt));
    chk({nm, "_err_code"}, VW'(err_code), VW'(m_err));
    chk({nm, "_pulses"}, VW'({hand_valid, play_valid, pass_valid, frame_err}), VW'(0));
  endtask

  int   npulse;
  int   act_kind;
  exp_t e_mon;
  string n_mon;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      npulse = int'(hand_valid) + int'(play_valid) + int'(pass_valid) + int'(frame_err);
      if (npulse != 0) begin
        chk("pulse_count", VW'(npulse), VW'(1));
        act_kind = hand_valid ? K_HAND : play_valid ? K_PLAY : pass_valid ? K_PASS : K_ERR;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d expected none", act_kind);
        end else begin
          e_mon = exp_q.pop_front();
          n_mon = name_q.pop_front();
          chk({n_mon, "_kind"}, VW'(act_kind), VW'(e_mon.kind));
          chk({n_mon, "_hand_cards"}, hand_cards, e_mon.hand);
          chk({n_mon, "_hand_cnt"}, VW'(hand_cnt), VW'(e_mon.hcnt));
          chk({n_mon, "_first_out"}, VW'(first_out), VW'(e_mon.first));
          chk({n_mon, "_play_cards"}, play_cards, e_mon.play);
          chk({n_mon, "_play_cnt"}, VW'(play_cnt), VW'(e_mon.pcnt));
          chk({n_mon, "_err_code"}, VW'(err_code), VW'(e_mon.err));
        end
      end
    end
  end

  task automatic send_bytes(input byte_q_t b, input int gap);
    foreach (b[i]) begin
      rx_data  = b[i];
      rx_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      rx_valid = 1'b0;
      repeat (gap) begin
        @(posedge sys_clk);
        #1;
      end
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_wait: pending events %0d expected 0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
    repeat (3) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  byte_q_t q, c;

  initial begin
    sys_rst  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    m_hand = '0; m_hcnt = '0; m_first = 1'b0;
    m_play = '0; m_pcnt = '0; m_err = 2'b00;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    check_outputs("reset");

    // play with remapped 2 and ace
    c = '{8'hF5, 8'hE5};
    m_play = pack(c); m_pcnt = 2;
    expect_ev(K_PLAY, "play2");
    q = '{8'hF2, 8'h02, 8'h02, 8'h25, 8'h15};
    send_bytes(q, 0);
    wait_done("play2", 20);

    // reset in the middle of a deal
    q = '{8'hF1, 8'hFA, 8'h11, 8'h3C, 8'h21};
    send_bytes(q, 0);
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    m_hand = '0; m_hcnt = '0; m_first = 1'b0;
    m_play = '0; m_pcnt = '0; m_err = 2'b00;
    check_outputs("mid_reset");
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;

    // 17-card deal, FPGA first
    c = '{8'h3C, 8'hF1, 8'hEA, 8'h4B, 8'h5C, 8'h6D, 8'h7E, 8'h8F, 8'h9A,
          8'hAB, 8'hBC, 8'hCD, 8'hD1, 8'hFA, 8'hE3, 8'hE4, 8'hF5};
    m_hand = pack(c); m_hcnt = 17; m_first = 1'b1;
    expect_ev(K_HAND, "deal17");
    q = '{8'hF1, 8'hFA, 8'h11, 8'h3C, 8'h21, 8'h1A, 8'h4B, 8'h5C, 8'h6D, 8'h7E, 8'h8F,
          8'h9A, 8'hAB, 8'hBC, 8'hCD, 8'hD1, 8'h2A, 8'h13, 8'hE4, 8'hF5};
    send_bytes(q, 0);
    wait_done("deal17", 40);

    // non-header bytes in IDLE are ignored, then a slow but in-time play
    q = '{8'h55, 8'h00, 8'hF3};
    send_bytes(q, 0);
    c = '{8'hED};
    m_play = pack(c); m_pcnt = 1;
    expect_ev(K_PLAY, "slow_play");
    q = '{8'hF2, 8'h01, 8'h01, 8'h1D};
    send_bytes(q, TMO - 4);
    wait_done("slow_play", 20);

    expect_ev(K_PASS, "pass");
    q = '{8'hF0, 8'hF0, 8'h00};
    send_bytes(q, 0);
    wait_done("pass", 20);

    m_err = 2'b01;
    expect_ev(K_ERR, "bad_sub_deal");
    q = '{8'hF1, 8'hFC};
    send_bytes(q, 0);
    wait_done("bad_sub_deal", 20);

    m_err = 2'b10;
    expect_ev(K_ERR, "len_zero");
    q = '{8'hF2, 8'h01, 8'h00};
    send_bytes(q, 0);
    wait_done("len_zero", 20);

    m_err = 2'b01;
    expect_ev(K_ERR, "bad_sub_pass");
    q = '{8'hF0, 8'hF1};
    send_bytes(q, 0);
    wait_done("bad_sub_pass", 20);

    m_err = 2'b10;
    expect_ev(K_ERR, "len_21");
    q = '{8'hF2, 8'h01, 8'h15};
    send_bytes(q, 0);
    wait_done("len_21", 20);

    // maximum length play
    q = '{8'hF2, 8'h01, 8'h14, 8'h2A, 8'h1B};
    c = '{8'hFA, 8'hEB};
    for (int i = 0; i < 18; i++) begin
      q.push_back(8'(8'h40 + i));
      c.push_back(8'(8'h40 + i));
    end
    m_play = pack(c); m_pcnt = 20;
    expect_ev(K_PLAY, "play20");
    send_bytes(q, 0);
    wait_done("play20", 40);

    m_err = 2'b11;
    expect_ev(K_ERR, "timeout");
    q = '{8'hF2, 8'h01, 8'h02};
    send_bytes(q, 0);
    wait_done("timeout", 4 * TMO);

    c = '{8'h33};
    m_play = pack(c); m_pcnt = 1;
    expect_ev(K_PLAY, "after_timeout");
    q = '{8'hF2, 8'h01, 8'h01, 8'h33};
    send_bytes(q, 0);
    wait_done("after_timeout", 20);

    c = '{8'hE1, 8'hF2, 8'h33};
    m_hand = pack(c); m_hcnt = 3; m_first = 1'b0;
    expect_ev(K_HAND, "deal_fb");
    q = '{8'hF1, 8'hFB, 8'h03, 8'h11, 8'h22, 8'h33};
    send_bytes(q, 0);
    wait_done("deal_fb", 20);

    // back-to-back: deal header lands the cycle after the play commit
    c = '{8'h44};
    m_play = pack(c); m_pcnt = 1;
    expect_ev(K_PLAY, "b2b_play");
    c = '{8'hF5};
    m_hand = pack(c); m_hcnt = 1; m_first = 1'b1;
    expect_ev(K_HAND, "b2b_deal");
    q = '{8'hF2, 8'h02, 8'h01, 8'h44, 8'hF1, 8'hFA, 8'h01, 8'h25};
    send_bytes(q, 0);
    wait_done("b2b", 30);

    repeat (3 * TMO) @(posedge sys_clk);
    #1;
    check_outputs("idle_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
